// File: rtl/id_ex_pipe_reg_if.sv
// Bundles the ID-stage inputs and the EX-stage outputs of the ID/EX pipeline register.
// The master drives the decode-side inputs; the slave is the pipeline register itself.
interface id_ex_pipe_reg_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              id_valid_i;
  logic              flush_i;
  logic [DATA_W-1:0] pc_plus4_i;
  logic [DATA_W-1:0] rs_data_i;
  logic [DATA_W-1:0] rt_data_i;
  logic [DATA_W-1:0] imm_ext_i;
  logic [REG_AW-1:0] rs_i;
  logic [REG_AW-1:0] rt_i;
  logic [REG_AW-1:0] rd_i;
  logic [9:0]        ctrl_i;

  logic [DATA_W-1:0] pc_plus4_o;
  logic [DATA_W-1:0] rs_data_o;
  logic [DATA_W-1:0] rt_data_o;
  logic [DATA_W-1:0] imm_ext_o;
  logic [REG_AW-1:0] rs_o;
  logic [REG_AW-1:0] rt_o;
  logic [REG_AW-1:0] rd_o;
  logic [9:0]        ctrl_o;
  logic              valid_o;
  logic              pc_write_o;
  logic              if_id_write_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  modport master (
    output id_valid_i, flush_i, pc_plus4_i, rs_data_i, rt_data_i, imm_ext_i,
           rs_i, rt_i, rd_i, ctrl_i,
    input  pc_plus4_o, rs_data_o, rt_data_o, imm_ext_o, rs_o, rt_o, rd_o,
           ctrl_o, valid_o, pc_write_o, if_id_write_o, stall_cnt_o
  );

  modport slave (
    input  id_valid_i, flush_i, pc_plus4_i, rs_data_i, rt_data_i, imm_ext_i,
           rs_i, rt_i, rd_i, ctrl_i,
    output pc_plus4_o, rs_data_o, rt_data_o, imm_ext_o, rs_o, rt_o, rd_o,
           ctrl_o, valid_o, pc_write_o, if_id_write_o, stall_cnt_o
  );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use hazard detection, branch flush and a
// saturating stall-cycle counter for performance reporting.
module id_ex_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input logic             clk_i,
  input logic             rst_i,
  id_ex_pipe_reg_if.slave bus
);
  localparam int CTRL_W       = 10;
  localparam int CTRL_MEMREAD = 7;

  logic [DATA_W-1:0] r_pcPlus4;
  logic [DATA_W-1:0] r_rsData;
  logic [DATA_W-1:0] r_rtData;
  logic [DATA_W-1:0] r_immExt;
  logic [REG_AW-1:0] r_rs;
  logic [REG_AW-1:0] r_rt;
  logic [REG_AW-1:0] r_rd;
  logic [CTRL_W-1:0] r_ctrl;
  logic              r_valid;
  logic [CNT_W-1:0]  r_stallCnt;

  logic w_rtNonZero;
  logic w_rtMatch;
  logic w_hazard;
  logic w_stall;
  logic w_bubble;
  logic w_cntSat;

  // A load in EX whose destination feeds the ID instruction; $0 is never a real dependency.
  assign w_rtNonZero = (r_rt != '0);
  assign w_rtMatch   = (r_rt == bus.rs_i) || (r_rt == bus.rt_i);
  assign w_hazard    = r_valid && r_ctrl[CTRL_MEMREAD] && w_rtNonZero &&
                       bus.id_valid_i && w_rtMatch;

  // A flushed instruction is discarded anyway, so it must not hold the front end.
  assign w_stall  = w_hazard && !bus.flush_i;
  assign w_bubble = bus.flush_i || w_hazard || !bus.id_valid_i;
  assign w_cntSat = (r_stallCnt == {CNT_W{1'b1}});

  assign bus.pc_write_o    = rst_i || !w_stall;
  assign bus.if_id_write_o = rst_i || !w_stall;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pcPlus4  <= '0;
      r_rsData   <= '0;
      r_rtData   <= '0;
      r_immExt   <= '0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_rd       <= '0;
      r_ctrl     <= '0;
      r_valid    <= 1'b0;
      r_stallCnt <= '0;
    end else begin
      r_pcPlus4 <= bus.pc_plus4_i;
      r_rsData  <= bus.rs_data_i;
      r_rtData  <= bus.rt_data_i;
      r_immExt  <= bus.imm_ext_i;
      r_rs      <= bus.rs_i;
      r_rt      <= bus.rt_i;
      r_rd      <= bus.rd_i;
      if (w_bubble) begin
        r_ctrl  <= '0;
        r_valid <= 1'b0;
      end else begin
        r_ctrl  <= bus.ctrl_i;
        r_valid <= 1'b1;
      end
      if (w_stall && !w_cntSat) begin
        r_stallCnt <= r_stallCnt + CNT_W'(1);
      end
    end
  end

  assign bus.pc_plus4_o  = r_pcPlus4;
  assign bus.rs_data_o   = r_rsData;
  assign bus.rt_data_o   = r_rtData;
  assign bus.imm_ext_o   = r_immExt;
  assign bus.rs_o        = r_rs;
  assign bus.rt_o        = r_rt;
  assign bus.rd_o        = r_rd;
  assign bus.ctrl_o      = r_ctrl;
  assign bus.valid_o     = r_valid;
  assign bus.stall_cnt_o = r_stallCnt;
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg: a 2-bit-counter instance and a default instance
// see identical stimulus so saturation and plain counting are both observed.
module tb_id_ex_pipe_reg;
  localparam logic [9:0] CTRL_LW  = 10'b1110010000;
  localparam logic [9:0] CTRL_ADD = 10'b1000001010;
  localparam logic [9:0] CTRL_T2  = 10'b1000011010;

  logic clk_i;
  logic rst_i;
  int   checks;
  int   errors;

  id_ex_pipe_reg_if #(.DATA_W(32), .REG_AW(5), .CNT_W(2))  bus ();
  id_ex_pipe_reg_if #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) busBig ();

  id_ex_pipe_reg #(.DATA_W(32), .REG_AW(5), .CNT_W(2)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  id_ex_pipe_reg #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) dutBig (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (busBig.slave)
  );

  // The default-width instance mirrors every input of the small one.
  assign busBig.id_valid_i = bus.id_valid_i;
  assign busBig.flush_i    = bus.flush_i;
  assign busBig.pc_plus4_i = bus.pc_plus4_i;
  assign busBig.rs_data_i  = bus.rs_data_i;
  assign busBig.rt_data_i  = bus.rt_data_i;
  assign busBig.imm_ext_i  = bus.imm_ext_i;
  assign busBig.rs_i       = bus.rs_i;
  assign busBig.rt_i       = bus.rt_i;
  assign busBig.rd_i       = bus.rd_i;
  assign busBig.ctrl_i     = bus.ctrl_i;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic applyStimulus(input logic valid, input logic flush,
                               input logic [31:0] pc, input logic [31:0] rsData,
                               input logic [31:0] rtData, input logic [31:0] imm,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd, input logic [9:0] ctrl);
    bus.id_valid_i = valid;
    bus.flush_i    = flush;
    bus.pc_plus4_i = pc;
    bus.rs_data_i  = rsData;
    bus.rt_data_i  = rtData;
    bus.imm_ext_i  = imm;
    bus.rs_i       = rs;
    bus.rt_i       = rt;
    bus.rd_i       = rd;
    bus.ctrl_i     = ctrl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    applyStimulus(1'b1, 1'b0, $urandom, $urandom, $urandom, $urandom,
                  5'($urandom), 5'($urandom), 5'($urandom), 10'($urandom));
    tick();
    applyStimulus(1'b1, 1'b0, $urandom, $urandom, $urandom, $urandom,
                  5'($urandom), 5'($urandom), 5'($urandom), CTRL_LW);
    tick();
    checks++;
    if (bus.valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %0h want 0", bus.valid_o); end
    checks++;
    if (bus.ctrl_o !== 10'h0) begin errors++; $display("[TB] FAIL reset_ctrl got %0h want 0", bus.ctrl_o); end
    checks++;
    if ({bus.pc_plus4_o, bus.rs_data_o, bus.rt_data_o, bus.imm_ext_o} !== 128'h0) begin
      errors++; $display("[TB] FAIL reset_data got %0h %0h %0h %0h want 0", bus.pc_plus4_o, bus.rs_data_o, bus.rt_data_o, bus.imm_ext_o);
    end
    checks++;
    if ({bus.rs_o, bus.rt_o, bus.rd_o} !== 15'h0) begin
      errors++; $display("[TB] FAIL reset_regs got %0h %0h %0h want 0", bus.rs_o, bus.rt_o, bus.rd_o);
    end
    checks++;
    if (bus.stall_cnt_o !== 2'd0 || busBig.stall_cnt_o !== 16'd0) begin
      errors++; $display("[TB] FAIL reset_cnt got %0d/%0d want 0/0", bus.stall_cnt_o, busBig.stall_cnt_o);
    end
    checks++;
    if (bus.pc_write_o !== 1'b1 || bus.if_id_write_o !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_enables got %b%b want 11", bus.pc_write_o, bus.if_id_write_o);
    end
    rst_i = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 10'h0);
    tick();
  endtask

  task automatic test_normal();
    applyStimulus(1'b1, 1'b0, 32'h0000_0104, 32'hA5A5_0001, 32'h1234_5678, 32'hFFFF_8000,
                  5'd1, 5'd2, 5'd3, CTRL_T2);
    checks++;
    if (bus.valid_o !== 1'b0) begin errors++; $display("[TB] FAIL normal_early got %0h want 0", bus.valid_o); end
    tick();
    checks++;
    if (bus.imm_ext_o !== 32'hFFFF_8000) begin errors++; $display("[TB] FAIL normal_imm got %0h want ffff8000", bus.imm_ext_o); end
    checks++;
    if (bus.rt_data_o !== 32'h1234_5678) begin errors++; $display("[TB] FAIL normal_rtdata got %0h want 12345678", bus.rt_data_o); end
    checks++;
    if (bus.ctrl_o !== CTRL_T2) begin errors++; $display("[TB] FAIL normal_ctrl got %0h want %0h", bus.ctrl_o, CTRL_T2); end
    checks++;
    if (bus.valid_o !== 1'b1) begin errors++; $display("[TB] FAIL normal_valid got %0h want 1", bus.valid_o); end
    checks++;
    if ({bus.pc_plus4_o, bus.rs_data_o} !== {32'h0000_0104, 32'hA5A5_0001}) begin
      errors++; $display("[TB] FAIL normal_pc_rs got %0h %0h want 104 a5a50001", bus.pc_plus4_o, bus.rs_data_o);
    end
    checks++;
    if ({bus.rs_o, bus.rt_o, bus.rd_o} !== {5'd1, 5'd2, 5'd3}) begin
      errors++; $display("[TB] FAIL normal_regs got %0d %0d %0d want 1 2 3", bus.rs_o, bus.rt_o, bus.rd_o);
    end
  endtask

  task automatic test_load_use();
    applyStimulus(1'b1, 1'b0, 32'h108, 32'h0, 32'h0, 32'h4, 5'd9, 5'd8, 5'd0, CTRL_LW);
    checks++;
    if (bus.pc_write_o !== 1'b1) begin errors++; $display("[TB] FAIL lu_nostall got %0h want 1", bus.pc_write_o); end
    tick();
    applyStimulus(1'b1, 1'b0, 32'h10C, 32'h11, 32'h22, 32'h0, 5'd8, 5'd10, 5'd11, CTRL_ADD);
    checks++;
    if (bus.pc_write_o !== 1'b0 || bus.if_id_write_o !== 1'b0) begin
      errors++; $display("[TB] FAIL lu_stall got %b%b want 00", bus.pc_write_o, bus.if_id_write_o);
    end
    tick();
    checks++;
    if (bus.ctrl_o !== 10'h0 || bus.valid_o !== 1'b0) begin
      errors++; $display("[TB] FAIL lu_bubble got ctrl %0h valid %0h want 0 0", bus.ctrl_o, bus.valid_o);
    end
    checks++;
    if (bus.stall_cnt_o !== 2'd1) begin errors++; $display("[TB] FAIL lu_cnt got %0d want 1", bus.stall_cnt_o); end
    checks++;
    if (bus.rs_o !== 5'd8) begin errors++; $display("[TB] FAIL lu_bubble_data got %0d want 8", bus.rs_o); end
    checks++;
    if (bus.pc_write_o !== 1'b1 || bus.if_id_write_o !== 1'b1) begin
      errors++; $display("[TB] FAIL lu_release got %b%b want 11", bus.pc_write_o, bus.if_id_write_o);
    end
    tick();
    checks++;
    if (bus.valid_o !== 1'b1 || bus.ctrl_o !== CTRL_ADD || bus.rd_o !== 5'd11) begin
      errors++; $display("[TB] FAIL lu_capture got valid %0h ctrl %0h rd %0d want 1 %0h 11", bus.valid_o, bus.ctrl_o, bus.rd_o, CTRL_ADD);
    end
    checks++;
    if (bus.stall_cnt_o !== 2'd1) begin errors++; $display("[TB] FAIL lu_cnt_hold got %0d want 1", bus.stall_cnt_o); end
  endtask

  task automatic test_zero_reg();
    applyStimulus(1'b1, 1'b0, 32'h200, 32'h0, 32'h0, 32'h8, 5'd4, 5'd0, 5'd0, CTRL_LW);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h204, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd12, CTRL_ADD);
    checks++;
    if (bus.pc_write_o !== 1'b1 || bus.if_id_write_o !== 1'b1) begin
      errors++; $display("[TB] FAIL zero_nostall got %b%b want 11", bus.pc_write_o, bus.if_id_write_o);
    end
    tick();
    checks++;
    if (bus.valid_o !== 1'b1 || bus.stall_cnt_o !== 2'd1) begin
      errors++; $display("[TB] FAIL zero_after got valid %0h cnt %0d want 1 1", bus.valid_o, bus.stall_cnt_o);
    end
  endtask

  task automatic test_flush();
    applyStimulus(1'b1, 1'b0, 32'h300, 32'h0, 32'h0, 32'h0, 5'd6, 5'd5, 5'd0, CTRL_LW);
    tick();
    applyStimulus(1'b1, 1'b1, 32'h304, 32'h0, 32'h0, 32'h0, 5'd5, 5'd7, 5'd13, CTRL_ADD);
    checks++;
    if (bus.pc_write_o !== 1'b1 || bus.if_id_write_o !== 1'b1) begin
      errors++; $display("[TB] FAIL flush_enables got %b%b want 11", bus.pc_write_o, bus.if_id_write_o);
    end
    tick();
    checks++;
    if (bus.ctrl_o !== 10'h0 || bus.valid_o !== 1'b0 || bus.rs_o !== 5'd5) begin
      errors++; $display("[TB] FAIL flush_bubble got ctrl %0h valid %0h rs %0d want 0 0 5", bus.ctrl_o, bus.valid_o, bus.rs_o);
    end
    checks++;
    if (bus.stall_cnt_o !== 2'd1) begin errors++; $display("[TB] FAIL flush_cnt got %0d want 1", bus.stall_cnt_o); end
  endtask

  task automatic test_invalid();
    applyStimulus(1'b0, 1'b0, 32'h400, 32'h0, 32'h0, 32'hDEAD_BEEF, 5'd1, 5'd2, 5'd3, CTRL_ADD);
    tick();
    checks++;
    if (bus.ctrl_o !== 10'h0 || bus.valid_o !== 1'b0 || bus.imm_ext_o !== 32'hDEAD_BEEF) begin
      errors++; $display("[TB] FAIL invalid got ctrl %0h valid %0h imm %0h want 0 0 deadbeef", bus.ctrl_o, bus.valid_o, bus.imm_ext_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  expSmall [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    logic [15:0] expBig   [5] = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h500, 32'h0, 32'h0, 32'h0, 5'd1, 5'd8, 5'd0, CTRL_LW);
      tick();
      if (i % 2 == 0)
        applyStimulus(1'b1, 1'b0, 32'h504, 32'h0, 32'h0, 32'h0, 5'd8, 5'd2, 5'd3, CTRL_ADD);
      else
        applyStimulus(1'b1, 1'b0, 32'h504, 32'h0, 32'h0, 32'h0, 5'd2, 5'd8, 5'd3, CTRL_ADD);
      tick();
      checks++;
      if (bus.stall_cnt_o !== expSmall[i] || busBig.stall_cnt_o !== expBig[i]) begin
        errors++; $display("[TB] FAIL sat_cnt%0d got %0d/%0d want %0d/%0d", i, bus.stall_cnt_o, busBig.stall_cnt_o, expSmall[i], expBig[i]);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    applyStimulus(1'b1, 1'b0, 32'h600, 32'h0, 32'h0, 32'h0, 5'd1, 5'd9, 5'd0, CTRL_LW);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h604, 32'h0, 32'h0, 32'h0, 5'd9, 5'd2, 5'd3, CTRL_ADD);
    rst_i = 1'b1;
    #1;
    checks++;
    if (bus.pc_write_o !== 1'b1 || bus.if_id_write_o !== 1'b1) begin
      errors++; $display("[TB] FAIL midrst_enables got %b%b want 11", bus.pc_write_o, bus.if_id_write_o);
    end
    tick();
    checks++;
    if (bus.valid_o !== 1'b0 || bus.rs_o !== 5'd0 || busBig.stall_cnt_o !== 16'd0) begin
      errors++; $display("[TB] FAIL midrst_clear got valid %0h rs %0d cnt %0d want 0 0 0", bus.valid_o, bus.rs_o, busBig.stall_cnt_o);
    end
    rst_i = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_i  = 1'b1;
    test_reset();
    test_normal();
    test_load_use();
    test_zero_reg();
    test_flush();
    test_invalid();
    test_back_to_back();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- ID/EX pipeline register for the 5-stage MIPS datapath, directly downstream of the decode-stage immediate extender and register file.
- Latches the 32-bit extended immediate, the register operands, the register specifiers and the decoded control bits for the EX stage.
- Contains the load-use hazard detector, which stalls PC and IF/ID and inserts a bubble.
- Applies branch flush and counts stall cycles for performance reporting.

Parameters:
DATA_W, 32, width of operand, immediate and PC datapaths
REG_AW, 5, register specifier width
CNT_W, 16, stall counter width (saturating)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous reset, active-high
id_valid_i  in  1  ID-stage instruction valid (0 = IF/ID holds a bubble)
flush_i  in  1  branch-taken flush from EX/MEM; kills the ID-stage instruction
pc_plus4_i  in  DATA_W  PC+4 of the ID-stage instruction
rs_data_i  in  DATA_W  register file read port 1
rt_data_i  in  DATA_W  register file read port 2
imm_ext_i  in  DATA_W  sign/zero-extended immediate from the extender
rs_i, rt_i, rd_i  in  REG_AW each  instruction register fields
ctrl_i  in  10  {reg_write, mem_to_reg, mem_read, mem_write, branch, alu_src, reg_dst, alu_op[2:0]}
pc_plus4_o, rs_data_o, rt_data_o, imm_ext_o  out  DATA_W each  registered copies
rs_o, rt_o, rd_o  out  REG_AW each  registered specifiers
ctrl_o  out  10  registered control, same packing as ctrl_i
valid_o  out  1  EX-stage instruction valid
pc_write_o  out  1  PC update enable (combinational)
if_id_write_o  out  1  IF/ID register enable (combinational)
stall_cnt_o  out  CNT_W  number of load-use stall cycles

Behaviour:
- Reset (rst_i=1 at a clock edge): all registered outputs go to 0, including valid_o, ctrl_o and stall_cnt_o. Reset overrides all other inputs in that cycle.
- Hazard detection, combinational:
  - hazard = valid_o & ctrl_o.mem_read & (rt_o != 0) & id_valid_i & ((rt_o == rs_i) | (rt_o == rt_i)).
  - Register $0 never causes a hazard.
- Stall outputs:
  - pc_write_o = if_id_write_o = ~(hazard & ~flush_i).
  - flush_i masks the stall, because the stalled instruction is being discarded.
  - Both outputs read 1 during reset.
- Register update priority at each rising edge: rst_i > flush_i > hazard > normal.
  - flush_i=1: ctrl_o <= 0, valid_o <= 0; data and specifier fields load from inputs.
  - hazard=1: bubble. ctrl_o <= 0, valid_o <= 0; data and specifier fields load from inputs. IF/ID and PC hold via the enables, so the same instruction is re-presented next cycle.
  - id_valid_i=0: ctrl_o <= 0, valid_o <= 0, data fields load.
  - Normal: all fields load from inputs, valid_o <= 1.
- Latency: exactly 1 cycle from input to output. No backpressure beyond the load-use stall.
- Stall duration: exactly one cycle per load-use pair. After the bubble, valid_o=0, so the hazard deasserts.
- stall_cnt_o:
  - Increments by 1 on each edge where hazard & ~flush_i & ~rst_i.
  - Saturates at 2^CNT_W-1; no wrap.
- Data fields are passed through without modification; widths are fixed, with no extension or truncation inside the block.
- Reset asserted mid-stall: the next edge clears everything. The hazard cannot persist because valid_o=0.

Test Plan:
1. Reset: rst_i=1 for 2 cycles with random inputs -> all outputs 0, pc_write_o=1, if_id_write_o=1, stall_cnt_o=0.
2. Normal capture: imm_ext_i=32'hFFFF8000, rt_data_i=32'h12345678, ctrl_i=10'b1000011010, id_valid_i=1 -> exactly one cycle later imm_ext_o=32'hFFFF8000, rt_data_o=32'h12345678, ctrl_o=10'b1000011010, valid_o=1.
3. Load-use: first cycle lw with rt_i=8 (mem_read=1); next cycle add with rs_i=8 -> in that cycle pc_write_o=0 and if_id_write_o=0. Next edge: ctrl_o=0, valid_o=0, stall_cnt_o=1. Following cycle: enables back to 1 and the add captured with valid_o=1.
4. $0 exemption: lw with rt_i=0 followed by rs_i=0 -> no stall, stall_cnt_o unchanged.
5. Flush vs. hazard: hazard condition present with flush_i=1 -> pc_write_o=1, ctrl_o=0 and valid_o=0 after the edge, stall_cnt_o unchanged.
6. Saturation: CNT_W=2, 5 consecutive load-use pairs -> stall_cnt_o reads 1, 2, 3, 3, 3.
